repcmps_seq: RTL and testbench

Sequencer for the string-compare instruction family (CMPS with no prefix, REPE, or REPNE) in the execute stage. It accepts one operand pair per cycle from the memory-read side over a valid/ready handshake. Each pair is compared as unsigned at byte, word or dword width. The sequencer decrements the repeat count and stops on the x86 termination condition. On completion it reports the final count and the ZF/CF results to the flags/writeback logic.

---
 rtl/repcmps_seq.sv | 139 +++++++++++++
 tb/tb_repcmps_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/repcmps_seq.sv
// Execute-stage sequencer for CMPS / REPE CMPS / REPNE CMPS: consumes one operand
// pair per cycle, tracks ECX and reports the final count plus ZF/CF on completion.
module repcmps_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       rep_mode,
  input  logic [1:0]       size,
  input  logic [CNT_W-1:0] count_in,
  input  logic             abort,
  input  logic             op_valid,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_out,
  output logic             zf,
  output logic             cf,
  output logic             flags_upd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_REPE  = 2'd1;
  localparam logic [1:0] M_REPNE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             seen_q, seen_d;

  logic             is_rep;
  logic             accept;
  logic             eq;
  logic             lt;
  logic [31:0]      a_m;
  logic [31:0]      b_m;
  logic [CNT_W-1:0] cnt_dec;

  function automatic logic [31:0] mask_sz(input logic [1:0] sz, input logic [31:0] v);
    case (sz)
      2'b00:   return {24'd0, v[7:0]};
      2'b01:   return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign is_rep   = (mode_q == M_REPE) || (mode_q == M_REPNE);
  assign a_m      = mask_sz(size_q, op_a);
  assign b_m      = mask_sz(size_q, op_b);
  assign eq       = (a_m == b_m);
  assign lt       = (a_m < b_m);
  assign cnt_dec  = cnt_q - CNT_W'(1);

  // abort wins over a pending pair: the handshake is withheld so nothing is consumed
  assign op_ready = (state_q == S_WAIT) && !abort;
  assign accept   = op_ready && op_valid;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign flags_upd = done && seen_q;
  assign count_out = cnt_q;
  assign zf        = zf_q;
  assign cf        = cf_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    seen_d  = seen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = (rep_mode == 2'b11) ? M_NONE : rep_mode;
          size_d  = size;
          cnt_d   = count_in;
          seen_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = (is_rep && (cnt_q == '0)) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (accept) begin
          zf_d   = eq;
          cf_d   = lt;
          seen_d = 1'b1;
          if (is_rep) cnt_d = cnt_dec;
          // the count test uses the decremented value, so a REP never wraps below zero
          if (!is_rep || ((mode_q == M_REPE) && !eq) || ((mode_q == M_REPNE) && eq) ||
              (cnt_dec == '0))
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_NONE;
      size_q  <= 2'b00;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: tb/tb_repcmps_seq.sv
// Bench for repcmps_seq: directed string-compare cases plus randomized instructions,
// checked every cycle against a transaction-level model of the CMPS rules.
module tb_repcmps_seq;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [1:0]       rep_mode;
  logic [1:0]       size;
  logic [CNT_W-1:0] count_in;
  logic             abort;
  logic             op_valid;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count_out;
  logic             zf;
  logic             cf;
  logic             flags_upd;

  int checks = 0;
  int errors = 0;

  // model view of the architectural results and of the expected control outputs
  logic [CNT_W-1:0] m_cnt;
  logic             m_zf, m_cf, m_seen;
  logic             exp_busy, exp_ready, exp_done, chk_on;
  logic [31:0]      pa[64];
  logic [31:0]      pb[64];

  // values the DUT showed during the last done cycle, for literal pinning
  int               n_acc;
  logic [CNT_W-1:0] d_cnt;
  logic             d_zf, d_cf, d_upd;

  repcmps_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rep_mode  (rep_mode),
    .size      (size),
    .count_in  (count_in),
    .abort     (abort),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_ready  (op_ready),
    .busy      (busy),
    .done      (done),
    .count_out (count_out),
    .zf        (zf),
    .cf        (cf),
    .flags_upd (flags_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] msk(input logic [1:0] sz, input logic [31:0] v);
    if (sz == 2'd0) return v % 32'd256;
    if (sz == 2'd1) return v % 32'd65536;
    return v;
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("op_ready", 64'(op_ready), 64'(exp_ready));
      chk("done", 64'(done), 64'(exp_done));
      chk("flags_upd", 64'(flags_upd), 64'(exp_done && m_seen));
      chk("count_out", 64'(count_out), 64'(m_cnt));
      chk("zf", 64'(zf), 64'(m_zf));
      chk("cf", 64'(cf), 64'(m_cf));
    end
  end

  // kill_kind: 0 = abort with a pair presented at index kill_at, 1 = reset at that point
  task automatic run_instr(input logic [1:0] mode, input logic [1:0] sz,
                           input logic [CNT_W-1:0] cnt, input int kill_at,
                           input int kill_kind, input int vpct);
    bit rep, fin, pend;
    int idx, cyc;
    logic [31:0] am, bm;
    logic [CNT_W-1:0] n_cnt;
    logic n_zf, n_cf;
    rep = (mode == 2'd1) || (mode == 2'd2);
    idx = 0; n_acc = 0; fin = 0; pend = 0; cyc = 0;
    n_cnt = '0; n_zf = 1'b0; n_cf = 1'b0;
    @(negedge clk);
    start = 1'b1; rep_mode = mode; size = sz; count_in = cnt;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0;
    @(negedge clk);
    start = 1'($urandom); rep_mode = 2'($urandom); size = 2'($urandom); count_in = $urandom;
    m_cnt = cnt; m_seen = 1'b0; exp_busy = 1'b1;
    if (rep && cnt == '0) begin
      @(negedge clk);
      exp_done = 1'b1;
      #3 d_cnt = count_out; d_zf = zf; d_cf = cf; d_upd = flags_upd;
    end else begin
      while (1) begin
        @(negedge clk);
        if (pend) begin
          m_zf = n_zf; m_cf = n_cf; m_cnt = n_cnt; m_seen = 1'b1; pend = 0;
        end
        if (fin) break;
        cyc++;
        if (cyc > 2000) begin
          chk("timeout", 64'(cyc), 64'(0));
          break;
        end
        start = 1'($urandom);
        if (idx == kill_at && kill_kind == 0) begin
          abort = 1'b1; op_valid = 1'b1; op_a = pa[idx % 64]; op_b = pb[idx % 64];
          exp_ready = 1'b0;
          @(negedge clk);
          abort = 1'b0; op_valid = 1'b0; start = 1'b0; exp_busy = 1'b0;
          return;
        end
        if (idx == kill_at && kill_kind == 1) begin
          reset_n = 1'b0;
          m_cnt = '0; m_zf = 1'b0; m_cf = 1'b0; m_seen = 1'b0;
          exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0;
          #1;
          chk("rst_async_busy", 64'(busy), 64'(0));
          chk("rst_async_ready", 64'(op_ready), 64'(0));
          chk("rst_async_count", 64'(count_out), 64'(0));
          chk("rst_async_flags", 64'({zf, cf, done, flags_upd}), 64'(0));
          @(negedge clk);
          reset_n = 1'b1; start = 1'b0; op_valid = 1'b0;
          return;
        end
        exp_ready = 1'b1;
        op_valid = ($urandom_range(99) < vpct);
        op_a = op_valid ? pa[idx % 64] : $urandom;
        op_b = op_valid ? pb[idx % 64] : $urandom;
        if (op_valid) begin
          am = msk(sz, op_a); bm = msk(sz, op_b);
          n_zf = (am == bm); n_cf = (am < bm);
          n_cnt = rep ? m_cnt - 1 : m_cnt;
          pend = 1; idx++; n_acc++;
          fin = !rep || (mode == 2'd1 && !n_zf) || (mode == 2'd2 && n_zf) || (n_cnt == '0);
        end
      end
      op_valid = 1'b0; exp_ready = 1'b0; exp_done = 1'b1;
      #3 d_cnt = count_out; d_zf = zf; d_cf = cf; d_upd = flags_upd;
    end
    @(negedge clk);
    start = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0;
    rep_mode = 2'd0; size = 2'd0; count_in = '0; op_a = '0; op_b = '0;
    m_cnt = '0; m_zf = 1'b0; m_cf = 1'b0; m_seen = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0; chk_on = 1'b0;
    n_acc = 0; d_cnt = '0; d_zf = 1'b0; d_cf = 1'b0; d_upd = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(op_ready), 64'(0));
    chk("reset_outs", 64'({done, zf, cf, flags_upd}), 64'(0));
    chk("reset_count", 64'(count_out), 64'(0));
    @(negedge clk);
    reset_n = 1'b1; chk_on = 1'b1;

    // REPE byte, mismatch on the third pair
    pa[0] = 32'h55; pb[0] = 32'h55; pa[1] = 32'h01; pb[1] = 32'h01;
    pa[2] = 32'h10; pb[2] = 32'h20;
    run_instr(2'd1, 2'd0, 32'd4, -1, 0, 100);
    chk("t1_accepts", 64'(n_acc), 64'(3));
    chk("t1_count", 64'(d_cnt), 64'(1));
    chk("t1_zf_cf_upd", 64'({d_zf, d_cf, d_upd}), 64'(3'b011));

    // REPNE dword, count runs out
    pa[0] = 32'd1; pb[0] = 32'd2; pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd0;
    pa[2] = 32'd7; pb[2] = 32'd8;
    run_instr(2'd2, 2'd2, 32'd3, -1, 0, 100);
    chk("t2_accepts", 64'(n_acc), 64'(3));
    chk("t2_count", 64'(d_cnt), 64'(0));
    chk("t2_zf_cf_upd", 64'({d_zf, d_cf, d_upd}), 64'(3'b011));

    // zero-count REPE keeps the previous flags
    run_instr(2'd1, 2'd0, 32'd0, -1, 0, 100);
    chk("t3_accepts", 64'(n_acc), 64'(0));
    chk("t3_zf_cf_upd", 64'({d_zf, d_cf, d_upd}), 64'(3'b010));
    chk("t3_count", 64'(d_cnt), 64'(0));

    // no prefix, word size: upper bits are masked away
    pa[0] = 32'h1234_8000; pb[0] = 32'h0000_8000;
    run_instr(2'd0, 2'd1, 32'd9, -1, 0, 100);
    chk("t4_accepts", 64'(n_acc), 64'(1));
    chk("t4_count", 64'(d_cnt), 64'(9));
    chk("t4_zf_cf_upd", 64'({d_zf, d_cf, d_upd}), 64'(3'b101));

    // abort with the third pair
    for (int i = 0; i < 8; i++) begin pa[i] = 32'h42 + i; pb[i] = 32'h42 + i; end
    run_instr(2'd1, 2'd0, 32'd10, 2, 0, 100);
    #3 chk("t5_count_after_abort", 64'(count_out), 64'(8));
    chk("t5_busy_after_abort", 64'(busy), 64'(0));

    // reset during WAIT_OP, then a clean REPE count 2
    run_instr(2'd1, 2'd2, 32'd5, 1, 1, 100);
    run_instr(2'd1, 2'd2, 32'd2, -1, 0, 100);
    chk("t6_accepts", 64'(n_acc), 64'(2));
    chk("t6_count", 64'(d_cnt), 64'(0));
    chk("t6_zf_upd", 64'({d_zf, d_upd}), 64'(2'b11));

    for (int t = 0; t < 150; t++) begin
      logic [1:0] md, sz;
      int kk, ka, r;
      md = 2'($urandom); sz = 2'($urandom);
      for (int i = 0; i < 64; i++) begin
        pa[i] = $urandom;
        r = $urandom_range(7);
        if (r < 4) pb[i] = pa[i];
        else if (r < 6) pb[i] = pa[i] ^ (32'h1 << $urandom_range(31, 8));
        else pb[i] = $urandom;
      end
      r = $urandom_range(99);
      ka = (r < 10 || (r >= 95)) ? $urandom_range(3) : -1;
      kk = (r >= 95) ? 1 : 0;
      run_instr(md, sz, ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(40)),
                ka, kk, $urandom_range(100, 40));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
